uart_mmio_ctrl: RTL

UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

---
 rtl/uart_ctrl_pkg.sv | 29 ++
 rtl/uart_mmio_ctrl_if.sv | 22 ++
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_mmio_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART memory-mapped controller: register map,
// STATUS bit positions and the TX/RX sequencer state encodings.
package uart_ctrl_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(5);

  localparam int unsigned ST_TX_NFULL  = 0;
  localparam int unsigned ST_RX_NEMPTY = 1;
  localparam int unsigned ST_TX_OVF    = 2;
  localparam int unsigned ST_RX_OVF    = 3;
  localparam int unsigned ST_TX_IDLE   = 4;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_WAIT_HI = 2'd1,
    TX_WAIT_LO = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_CLEAR    = 2'd1,
    RX_WAIT_LOW = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// Single-cycle request / registered-ack register bus used by the UART controller.
interface uart_mmio_ctrl_if;
  import uart_ctrl_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty flags and a combinational head.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full    <= (count_d == CNT_W'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Register-mapped UART controller: DATA/STATUS registers over a one-cycle bus,
// TX and RX byte FIFOs, and handshake sequencers toward the byte transmitter/receiver.
module uart_mmio_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_mmio_ctrl_if.slave   bus,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_clear
);

  tx_state_e         tx_state_q, tx_state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_ovf_set;
  logic              tx_start_d, rx_clear_d, ack_d;
  logic [DATA_W-1:0] tx_data_d, rdata_d, status;
  logic              wr_data, rd_data, rd_status;

  // Register decode; reserved offsets and STATUS writes fall through untouched
  always_comb begin
    wr_data   = bus.bus_req &  bus.bus_we & (bus.bus_addr == ADDR_DATA);
    rd_data   = bus.bus_req & ~bus.bus_we & (bus.bus_addr == ADDR_DATA);
    rd_status = bus.bus_req & ~bus.bus_we & (bus.bus_addr == ADDR_STATUS);
    rx_pop    = rd_data & ~rx_empty;
  end

  // TX sequencer: launch one byte, then follow tx_busy high and back low
  always_comb begin
    tx_state_d = tx_state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_head;
          tx_pop     = 1'b1;
          tx_state_d = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: if (tx_busy)  tx_state_d = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase
    tx_push = wr_data & (~tx_full | tx_pop);
  end

  // RX sequencer: capture once, pulse rx_clear, wait for the receiver to release
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clear_d = 1'b0;
    rx_push    = 1'b0;
    rx_ovf_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_ready) begin
          if (!rx_full || rx_pop) rx_push    = 1'b1;
          else                    rx_ovf_set = 1'b1;
          rx_clear_d = 1'b1;
          rx_state_d = RX_CLEAR;
        end
      end
      RX_CLEAR:    rx_state_d = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!rx_ready) rx_state_d = RX_IDLE;
      default:     rx_state_d = RX_IDLE;
    endcase
  end

  // Read data and sticky overflow flags; a new overflow wins over a STATUS clear
  always_comb begin
    status               = '0;
    status[ST_TX_NFULL]  = ~tx_full;
    status[ST_RX_NEMPTY] = ~rx_empty;
    status[ST_TX_OVF]    = tx_ovf_q;
    status[ST_RX_OVF]    = rx_ovf_q;
    status[ST_TX_IDLE]   = tx_empty & (tx_state_q == TX_IDLE);
    rdata_d = '0;
    if (rd_data)        rdata_d = rx_empty ? '0 : rx_head;
    else if (rd_status) rdata_d = status;
    ack_d    = bus.bus_req;
    tx_ovf_d = (tx_ovf_q & ~rd_status) | (wr_data & ~tx_push);
    rx_ovf_d = (rx_ovf_q & ~rd_status) | rx_ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q    <= TX_IDLE;
      rx_state_q    <= RX_IDLE;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      rx_clear      <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      tx_start      <= tx_start_d;
      tx_data       <= tx_data_d;
      rx_clear      <= rx_clear_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_ovf_q      <= rx_ovf_d;
      bus.bus_ack   <= ack_d;
      bus.bus_rdata <= rdata_d;
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus.bus_wdata),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule
